// File: rtl/eth_tx_packer.sv
// Serializes 32-bit result words MSB-first into the transmit byte FIFO and commits one frame-info entry per frame.
// Optional zero-padding of short frames up to MIN_PAYLOAD is compiled in with `define ETH_TX_PAD_EN.
module eth_tx_packer #(
    parameter int   MIN_PAYLOAD = 46,
    parameter int   MAX_PAYLOAD = 1500,
    parameter logic SRC_SEL     = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wordIn,
    input  logic        wordValid,
    input  logic        wordLast,
    output logic        wordReady,
    output logic [7:0]  txFifoIn,
    output logic        txWrEn,
    input  logic        txFifoFull,
    output logic [11:0] tfFifoIn,
    output logic        tfWrEn,
    input  logic        tfFifoFull,
    output logic        busy,
    output logic [15:0] frameCnt
);

    localparam logic [10:0] MAX_CNT = 11'(MAX_PAYLOAD);

    generate
        if ((MAX_PAYLOAD % 4) != 0 || MAX_PAYLOAD > 2047 || MAX_PAYLOAD < 4)
            $error("eth_tx_packer: MAX_PAYLOAD must be a multiple of 4 in 4..2047");
        if (MIN_PAYLOAD < 0 || MIN_PAYLOAD > MAX_PAYLOAD)
            $error("eth_tx_packer: MIN_PAYLOAD must lie in 0..MAX_PAYLOAD");
    endgenerate

`ifdef ETH_TX_PAD_EN
    localparam logic [10:0] MIN_CNT = 11'(MIN_PAYLOAD);
    typedef enum logic [1:0] {S_IDLE, S_SER, S_PAD, S_COMMIT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SER, S_COMMIT} state_t;
`endif

    state_t      r_state;
    logic [31:0] r_shift;
    logic        r_last;
    logic [1:0]  r_idx;
    logic [10:0] r_count;
    logic [15:0] r_frameCnt;
    logic        r_wordReady;
    logic        r_busy;

    logic        w_txWr;
    logic        w_tfWr;
    logic [10:0] w_cntInc;

    // Write strobes are gated by the full flags in the same cycle so nothing is ever written into a full FIFO.
    always_comb begin
        w_txWr   = 1'b0;
        w_tfWr   = 1'b0;
        w_cntInc = r_count + 11'd1;
        case (r_state)
            S_SER:    w_txWr = !txFifoFull;
`ifdef ETH_TX_PAD_EN
            S_PAD:    w_txWr = !txFifoFull;
`endif
            S_COMMIT: w_tfWr = !tfFifoFull;
            default:  ;
        endcase
    end

    assign txWrEn    = w_txWr;
    assign txFifoIn  = (r_state == S_SER) ? r_shift[31:24] : '0;
    assign tfWrEn    = w_tfWr;
    assign tfFifoIn  = (r_state == S_COMMIT) ? {SRC_SEL, r_count} : '0;
    assign wordReady = r_wordReady;
    assign busy      = r_busy;
    assign frameCnt  = r_frameCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_last      <= 1'b0;
            r_idx       <= '0;
            r_count     <= '0;
            r_frameCnt  <= '0;
            r_wordReady <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (wordValid && r_wordReady) begin
                        r_shift     <= wordIn;
                        r_last      <= wordLast;
                        r_idx       <= '0;
                        r_state     <= S_SER;
                        r_wordReady <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                S_SER: begin
                    if (w_txWr) begin
                        r_shift <= {r_shift[23:0], 8'h00};
                        r_idx   <= r_idx + 2'd1;
                        r_count <= w_cntInc;
                        if (r_idx == 2'd3) begin
                            // Reaching MAX_CNT without last closes this frame; the next word opens a new one.
                            if (r_last || w_cntInc == MAX_CNT) begin
`ifdef ETH_TX_PAD_EN
                                if (w_cntInc < MIN_CNT)
                                    r_state <= S_PAD;
                                else
                                    r_state <= S_COMMIT;
`else
                                r_state <= S_COMMIT;
`endif
                            end else begin
                                r_state     <= S_IDLE;
                                r_wordReady <= 1'b1;
                                r_busy      <= 1'b0;
                            end
                        end
                    end
                end
`ifdef ETH_TX_PAD_EN
                S_PAD: begin
                    if (w_txWr) begin
                        r_count <= w_cntInc;
                        if (w_cntInc == MIN_CNT)
                            r_state <= S_COMMIT;
                    end
                end
`endif
                S_COMMIT: begin
                    if (w_tfWr) begin
                        r_count     <= '0;
                        r_frameCnt  <= r_frameCnt + 16'd1;
                        r_state     <= S_IDLE;
                        r_wordReady <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_wordReady <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_packer.sv
// Scoreboard bench for eth_tx_packer: two instances (default sizes, and MAX_PAYLOAD=8 for splitting).
// Expected bytes/frame-info entries are queued at stimulus time and popped by a negedge monitor.
module tb_eth_tx_packer;

`ifdef ETH_TX_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    // Extra cycles a 4-byte frame spends padding on instance 0.
    localparam int PADC = PAD ? 42 : 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        txf = 1'b0;
    logic        tff = 1'b0;

    logic [31:0] wi0 = '0, wi1 = '0;
    logic        wv0 = 1'b0, wv1 = 1'b0;
    logic        wl0 = 1'b0, wl1 = 1'b0;
    logic        wr0, wr1, txe0, txe1, tfe0, tfe1, busy0, busy1;
    logic [7:0]  tx0, tx1;
    logic [11:0] tf0, tf1;
    logic [15:0] fc0, fc1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tf_cyc0 = -1;

    logic [7:0]  q_b0[$], q_b1[$];
    logic [11:0] q_f0[$], q_f1[$];
    int cnt0 = 0, cnt1 = 0, frames0 = 0, frames1 = 0;

    eth_tx_packer #(.MIN_PAYLOAD(46), .MAX_PAYLOAD(1500), .SRC_SEL(1'b0)) dut0 (
        .clk(clk), .reset(reset), .wordIn(wi0), .wordValid(wv0), .wordLast(wl0),
        .wordReady(wr0), .txFifoIn(tx0), .txWrEn(txe0), .txFifoFull(txf),
        .tfFifoIn(tf0), .tfWrEn(tfe0), .tfFifoFull(tff), .busy(busy0), .frameCnt(fc0)
    );

    eth_tx_packer #(.MIN_PAYLOAD(4), .MAX_PAYLOAD(8), .SRC_SEL(1'b1)) dut1 (
        .clk(clk), .reset(reset), .wordIn(wi1), .wordValid(wv1), .wordLast(wl1),
        .wordReady(wr1), .txFifoIn(tx1), .txWrEn(txe1), .txFifoFull(txf),
        .tfFifoIn(tf1), .tfWrEn(tfe1), .tfFifoFull(tff), .busy(busy1), .frameCnt(fc1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got write %0h with nothing expected (t=%0t)", name, act, $time);
    endtask

    always @(negedge clk) begin
        if (txe0) begin
            if (q_b0.size() == 0) unexpected("byte0", 32'(tx0));
            else check("byte0", 32'(tx0), 32'(q_b0.pop_front()));
        end
        if (txe1) begin
            if (q_b1.size() == 0) unexpected("byte1", 32'(tx1));
            else check("byte1", 32'(tx1), 32'(q_b1.pop_front()));
        end
        if (tfe0) begin
            tf_cyc0 = cyc;
            if (q_f0.size() == 0) unexpected("finfo0", 32'(tf0));
            else check("finfo0", 32'(tf0), 32'(q_f0.pop_front()));
        end
        if (tfe1) begin
            if (q_f1.size() == 0) unexpected("finfo1", 32'(tf1));
            else check("finfo1", 32'(tf1), 32'(q_f1.pop_front()));
        end
        if (txf) check("txWrEn_while_full", {30'd0, txe1, txe0}, 32'd0);
        if (tff) check("tfWrEn_while_full", {30'd0, tfe1, tfe0}, 32'd0);
    end

    // Reference behaviour of one word: 4 bytes MSB-first, then frame close/pad/commit bookkeeping.
    task automatic model_word(input int inst, input logic [31:0] w, input logic l);
        int mx, mn, c;
        logic src;
        mx  = (inst == 0) ? 1500 : 8;
        mn  = (inst == 0) ? 46 : 4;
        src = (inst == 0) ? 1'b0 : 1'b1;
        c   = (inst == 0) ? cnt0 : cnt1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (inst == 0) q_b0.push_back(w[31 - 8*i -: 8]);
            else           q_b1.push_back(w[31 - 8*i -: 8]);
        end
        c += 4;
        if (l || c == mx) begin
            if (PAD) begin
                while (c < mn) begin
                    if (inst == 0) q_b0.push_back(8'h00);
                    else           q_b1.push_back(8'h00);
                    c++;
                end
            end
            if (inst == 0) begin q_f0.push_back({src, 11'(c)}); frames0++; end
            else           begin q_f1.push_back({src, 11'(c)}); frames1++; end
            c = 0;
        end
        if (inst == 0) cnt0 = c; else cnt1 = c;
    endtask

    // Returns the cycle number of the accepting edge; leaves time at #1 after that edge.
    task automatic send(input int inst, input logic [31:0] w, input logic l, output int acc);
        int n;
        model_word(inst, w, l);
        @(negedge clk);
        if (inst == 0) begin wi0 = w; wl0 = l; wv0 = 1'b1; end
        else           begin wi1 = w; wl1 = l; wv1 = 1'b1; end
        n = 0;
        while (((inst == 0) ? !wr0 : !wr1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: wordReady got 0 expected 1 within 300 cycles");
        end
        acc = cyc;
        @(posedge clk);
        #1;
        wv0 = 1'b0;
        wv1 = 1'b0;
    endtask

    task automatic wait_idle(input int inst);
        int n;
        n = 0;
        while (((inst == 0) ? busy0 : busy1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 300), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_wordReady", 32'(wr0), 32'd1);
        check("rst_txWrEn",    32'(txe0), 32'd0);
        check("rst_tfWrEn",    32'(tfe0), 32'd0);
        check("rst_busy",      32'(busy0), 32'd0);
        check("rst_txFifoIn",  32'(tx0), 32'd0);
        check("rst_tfFifoIn",  32'(tf0), 32'd0);
        check("rst_frameCnt",  32'(fc0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time got 200000 expected completion earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, prev;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs();

        // Single terminal word: commit timing relative to acceptance.
        send(0, 32'hDEADBEEF, 1'b1, acc);
        wait_idle(0);
        check("single_commit_latency", 32'(tf_cyc0 - acc), 32'(5 + PADC));
        check("single_frameCnt", 32'(fc0), 32'd1);

        // 12-word frame: one word accepted every 5 cycles.
        prev = 0;
        for (int k = 0; k < 12; k++) begin
            send(0, {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)}, k == 11, acc);
            if (k > 0) check("word_interval", 32'(acc - prev), 32'd5);
            prev = acc;
        end
        wait_idle(0);

        // Byte backpressure for 3 cycles after the 2nd byte.
        send(0, 32'h01020304, 1'b1, acc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        txf = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        txf = 1'b0;
        wait_idle(0);
        check("bp_commit_latency", 32'(tf_cyc0 - acc), 32'(8 + PADC));

        // Commit stall: tfFifoFull held for 5 cycles in COMMIT.
        tff = 1'b1;
        send(0, 32'h55AA33CC, 1'b1, acc);
        repeat (4 + PADC) begin @(posedge clk); #1; end
        for (int k = 0; k < 5; k++) begin
            check("stall_tfWrEn",    32'(tfe0), 32'd0);
            check("stall_wordReady", 32'(wr0), 32'd0);
            @(posedge clk); #1;
        end
        tff = 1'b0;
        wait_idle(0);
        check("stall_commit_latency", 32'(tf_cyc0 - acc), 32'(10 + PADC));
        check("frameCnt_before_split", 32'(fc0), 32'(frames0));

        // Frame split on the MAX_PAYLOAD=8 instance.
        send(1, 32'h11223344, 1'b0, acc);
        send(1, 32'h55667788, 1'b0, acc);
        send(1, 32'h99AABBCC, 1'b1, acc);
        wait_idle(1);
        check("split_frameCnt", 32'(fc1), 32'd2);

        // Reset during SER: partial frame dropped, no frame-info write.
        send(0, 32'hCAFEF00D, 1'b1, acc);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        q_b0.delete(); q_b1.delete(); q_f0.delete(); q_f1.delete();
        cnt0 = 0; cnt1 = 0; frames0 = 0; frames1 = 0;
        check_reset_outputs();
        reset = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("post_reset_wordReady", 32'(wr0), 32'd1);

        // Recovery frame after reset.
        send(0, 32'h0A0B0C0D, 1'b0, acc);
        send(0, 32'h10203040, 1'b1, acc);
        wait_idle(0);
        check("recover_frameCnt", 32'(fc0), 32'(frames0));

        repeat (10) @(negedge clk);
        check("leftover_bytes0", 32'(q_b0.size()), 32'd0);
        check("leftover_finfo0", 32'(q_f0.size()), 32'd0);
        check("leftover_bytes1", 32'(q_b1.size()), 32'd0);
        check("leftover_finfo1", 32'(q_f1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
